// File: rtl/raster_dispatch.sv
// Round-robin triangle dispatcher feeding NUM_RAST rasterizers, with per-instance busy tracking
// and end-of-frame detection once the last triangle has been issued and every instance drained.
module raster_dispatch #(
   parameter int NUM_RAST  = 2,
   parameter int TRI_WIDTH = 288,
   parameter int TIMEOUT   = 15,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 tri_valid_in,
   output logic                 tri_ready_out,
   input  logic [TRI_WIDTH-1:0] tri_data_in,
   input  logic                 tri_last_in,
   output logic [NUM_RAST-1:0]  rast_valid_out,
   output logic [TRI_WIDTH-1:0] rast_data_out,
   input  logic [NUM_RAST-1:0]  rast_ready_in,
   output logic [NUM_RAST-1:0]  busy_out,
   output logic [CNT_WIDTH-1:0] tri_count_out,
   output logic                 frame_done_out,
   output logic                 timeout_err_out
);

   localparam int RRW = (NUM_RAST > 1) ? $clog2(NUM_RAST) : 1;
   localparam int TW  = $clog2(TIMEOUT + 1);

   typedef enum logic {
      ST_ACCEPT,
      ST_DRAIN
   } top_state_t;

   typedef enum logic [1:0] {
      TRK_FREE,
      TRK_ISSUED,
      TRK_ACTIVE
   } trk_state_t;

   top_state_t           state;
   top_state_t           state_next;
   logic                 hold_valid;
   logic [TRI_WIDTH-1:0] hold_data;
   logic [RRW-1:0]       rr_ptr;
   logic [RRW-1:0]       issue_sel;
   logic                 issue_found;
   logic                 do_issue;
   logic                 accept;
   logic [NUM_RAST-1:0]  free_vec;
   logic [NUM_RAST-1:0]  cand;
   logic [NUM_RAST-1:0]  timeout_hit;
   logic                 all_free;
   trk_state_t           trk      [NUM_RAST];
   trk_state_t           trk_next [NUM_RAST];
   logic [TW-1:0]        timer      [NUM_RAST];
   logic [TW-1:0]        timer_next [NUM_RAST];

   always_comb begin
      free_vec = '0;
      for (int i = 0; i < NUM_RAST; i++) begin
         free_vec[i] = (trk[i] == TRK_FREE);
      end
      busy_out = ~free_vec;
      all_free = &free_vec;
      cand     = free_vec & rast_ready_in;
   end

   // Lowest offset from the round-robin pointer wins; a tracker freed this cycle is only
   // eligible from the next cycle because selection looks at the registered state.
   always_comb begin
      issue_found = 1'b0;
      issue_sel   = '0;
      for (int k = NUM_RAST - 1; k >= 0; k--) begin
         logic [RRW-1:0] idx;
         idx = RRW'((int'(rr_ptr) + k) % NUM_RAST);
         if (cand[idx]) begin
            issue_found = 1'b1;
            issue_sel   = idx;
         end
      end
      do_issue = hold_valid && issue_found;
   end

   // A bare tri_last_in (no valid) while ready closes the frame without a triangle.
   always_comb begin
      state_next     = state;
      frame_done_out = 1'b0;
      tri_ready_out  = (state == ST_ACCEPT) && !hold_valid;
      accept         = tri_valid_in && tri_ready_out;
      case (state)
         ST_ACCEPT: begin
            if (tri_ready_out && tri_last_in) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!hold_valid && all_free) begin
               state_next     = ST_ACCEPT;
               frame_done_out = 1'b1;
            end
         end
      endcase
   end

   // The timer counts cycles spent in ISSUED, starting with the strobe cycle itself.
   always_comb begin
      timeout_hit = '0;
      for (int i = 0; i < NUM_RAST; i++) begin
         trk_next[i]   = trk[i];
         timer_next[i] = timer[i];
         case (trk[i])
            TRK_FREE: begin
               if (do_issue && (issue_sel == RRW'(i))) begin
                  trk_next[i]   = TRK_ISSUED;
                  timer_next[i] = '0;
               end
            end
            TRK_ISSUED: begin
               if (!rast_ready_in[i]) begin
                  trk_next[i] = TRK_ACTIVE;
               end else if (timer[i] == TW'(TIMEOUT - 1)) begin
                  trk_next[i]    = TRK_FREE;
                  timeout_hit[i] = 1'b1;
               end else begin
                  timer_next[i] = timer[i] + 1'b1;
               end
            end
            TRK_ACTIVE: begin
               if (rast_ready_in[i]) begin
                  trk_next[i] = TRK_FREE;
               end
            end
            default: trk_next[i] = TRK_FREE;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state           <= ST_ACCEPT;
         hold_valid      <= 1'b0;
         hold_data       <= '0;
         rr_ptr          <= '0;
         rast_valid_out  <= '0;
         rast_data_out   <= '0;
         tri_count_out   <= '0;
         timeout_err_out <= 1'b0;
         for (int i = 0; i < NUM_RAST; i++) begin
            trk[i]   <= TRK_FREE;
            timer[i] <= '0;
         end
      end else begin
         state          <= state_next;
         rast_valid_out <= '0;
         for (int i = 0; i < NUM_RAST; i++) begin
            trk[i]   <= trk_next[i];
            timer[i] <= timer_next[i];
         end
         if (|timeout_hit) begin
            timeout_err_out <= 1'b1;
         end
         if (accept) begin
            hold_valid <= 1'b1;
            hold_data  <= tri_data_in;
         end else if (do_issue) begin
            hold_valid     <= 1'b0;
            rast_data_out  <= hold_data;
            rast_valid_out <= NUM_RAST'(1) << issue_sel;
            rr_ptr         <= (issue_sel == RRW'(NUM_RAST - 1)) ? '0 : issue_sel + 1'b1;
            if (tri_count_out != '1) begin
               tri_count_out <= tri_count_out + 1'b1;
            end
         end
         if (frame_done_out) begin
            tri_count_out <= '0;
         end
      end
   end

endmodule

// File: tb/tb_raster_dispatch.sv
// Bench for raster_dispatch: vector table of single-triangle scenarios, hand sequences for
// multi-cycle corners, and a randomized run against a transaction-level reference model.
module tb_raster_dispatch;

   localparam int N   = 2;
   localparam int TW  = 288;
   localparam int TO  = 15;
   localparam int CW  = 16;
   localparam int BIG = 1000000000;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          tri_valid_in;
   logic          tri_ready_out;
   logic [TW-1:0] tri_data_in;
   logic          tri_last_in;
   logic [N-1:0]  rast_valid_out;
   logic [TW-1:0] rast_data_out;
   logic [N-1:0]  rast_ready_in;
   logic [N-1:0]  busy_out;
   logic [CW-1:0] tri_count_out;
   logic          frame_done_out;
   logic          timeout_err_out;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int lat       [N];
   int rem       [N];
   bit arm       [N];
   int free_from [N];
   int prev_free [N];
   bit rand_lat;

   typedef struct {
      logic [N-1:0]  ready_mask;
      int            lat;
      logic          last;
      logic [N-1:0]  exp_valid;
      int            exp_done;
      int            exp_err_dly;
      logic [CW-1:0] exp_cnt_end;
   } vec_t;

   vec_t vecs [6];

   int            r_strobe_dly, r_strobe_cnt, r_done_dly, r_done_cnt, r_err_dly;
   logic [N-1:0]  r_strobe_val;
   logic [TW-1:0] r_data;
   logic [CW-1:0] r_cnt_strobe, r_cnt_end;

   always #5 clk_in = ~clk_in;

   raster_dispatch #(
      .NUM_RAST (N),
      .TRI_WIDTH(TW),
      .TIMEOUT  (TO),
      .CNT_WIDTH(CW)
   ) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .tri_valid_in   (tri_valid_in),
      .tri_ready_out  (tri_ready_out),
      .tri_data_in    (tri_data_in),
      .tri_last_in    (tri_last_in),
      .rast_valid_out (rast_valid_out),
      .rast_data_out  (rast_data_out),
      .rast_ready_in  (rast_ready_in),
      .busy_out       (busy_out),
      .tri_count_out  (tri_count_out),
      .frame_done_out (frame_done_out),
      .timeout_err_out(timeout_err_out)
   );

   task automatic checkOutput(input string name, input logic [TW-1:0] actual, input logic [TW-1:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Rasterizer model: ready stays high through the strobe cycle, then drops for lat cycles
   // (lat==0 means it never acknowledges). free_from is the first cycle its tracker reads FREE.
   task automatic tick();
      @(posedge clk_in);
      #1;
      cyc++;
      prev_free = free_from;
      for (int i = 0; i < N; i++) begin
         if (rem[i] > 0) begin
            rem[i]--;
            if (rem[i] == 0) begin
               rast_ready_in[i] = 1'b1;
               free_from[i]     = cyc + 1;
            end
         end
         if (arm[i]) begin
            arm[i] = 1'b0;
            if (lat[i] > 0) begin
               rast_ready_in[i] = 1'b0;
               rem[i]           = lat[i];
            end
         end
         if (rast_valid_out[i] === 1'b1) begin
            arm[i]       = 1'b1;
            free_from[i] = BIG;
            if (rand_lat) lat[i] = $urandom_range(1, 8);
         end
      end
   endtask

   task automatic model_clear();
      rast_ready_in = '1;
      for (int i = 0; i < N; i++) begin
         rem[i]       = 0;
         arm[i]       = 1'b0;
         free_from[i] = 0;
         lat[i]       = 1;
      end
   endtask

   task automatic do_reset();
      rst_in       = 1'b1;
      tri_valid_in = 1'b0;
      tri_last_in  = 1'b0;
      tri_data_in  = '0;
      rand_lat     = 1'b0;
      model_clear();
      tick();
      tick();
      rst_in = 1'b0;
   endtask

   function automatic logic [TW-1:0] rand_tri();
      logic [TW-1:0] d;
      for (int w = 0; w < TW / 32; w++) d[w*32 +: 32] = $urandom();
      return d;
   endfunction

   task automatic applyStimulus(input vec_t v, input logic [TW-1:0] data);
      int t0;
      do_reset();
      for (int i = 0; i < N; i++) lat[i] = v.lat;
      rast_ready_in = v.ready_mask;
      tri_data_in   = data;
      tri_valid_in  = 1'b1;
      tri_last_in   = v.last;
      t0 = cyc;
      tick();
      tri_valid_in = 1'b0;
      tri_last_in  = 1'b0;
      r_strobe_dly = -1; r_strobe_cnt = 0; r_done_dly = -1; r_done_cnt = 0; r_err_dly = -1;
      r_strobe_val = '0; r_data = '0; r_cnt_strobe = '0;
      for (int k = 0; k < 60; k++) begin
         if (rast_valid_out != '0) begin
            r_strobe_cnt++;
            if (r_strobe_dly < 0) begin
               r_strobe_dly = cyc - t0;
               r_strobe_val = rast_valid_out;
               r_data       = rast_data_out;
               r_cnt_strobe = tri_count_out;
            end
         end
         if (frame_done_out) begin
            r_done_cnt++;
            if (r_done_dly < 0) r_done_dly = cyc - t0;
         end
         if (timeout_err_out && r_err_dly < 0) r_err_dly = cyc - t0;
         tick();
      end
      r_cnt_end = tri_count_out;
   endtask

   initial begin
      logic [TW-1:0] d;
      logic [TW-1:0] cdata [4];
      logic [N-1:0]  seq   [4];
      logic [TW-1:0] dseq  [4];
      int sent, pend, nstr, dones, viol;

      // Vector table: one triangle after reset, timing counted from its accept cycle.
      vecs[0] = '{2'b11,  1, 1'b1, 2'b01,  5, -1, 16'd0};
      vecs[1] = '{2'b11, 40, 1'b1, 2'b01, 44, -1, 16'd0};
      vecs[2] = '{2'b10,  3, 1'b1, 2'b10,  7, -1, 16'd0};
      vecs[3] = '{2'b11,  0, 1'b1, 2'b01, 17, 17, 16'd0};
      vecs[4] = '{2'b11,  3, 1'b0, 2'b01, -1, -1, 16'd1};
      vecs[5] = '{2'b01,  2, 1'b1, 2'b01,  6, -1, 16'd0};

      do_reset();
      checkOutput("rst_ready", tri_ready_out, 1'b1);
      checkOutput("rst_valid", rast_valid_out, '0);
      checkOutput("rst_data", rast_data_out, '0);
      checkOutput("rst_busy", busy_out, '0);
      checkOutput("rst_count", tri_count_out, '0);
      checkOutput("rst_done", frame_done_out, 1'b0);
      checkOutput("rst_err", timeout_err_out, 1'b0);

      for (int v = 0; v < 6; v++) begin
         d = rand_tri();
         applyStimulus(vecs[v], d);
         $display("[TB] vector %0d lat=%0d last=%0b", v, vecs[v].lat, vecs[v].last);
         checkOutput("vec_strobe_dly", r_strobe_dly, 2);
         checkOutput("vec_strobe_cnt", r_strobe_cnt, 1);
         checkOutput("vec_strobe_val", r_strobe_val, vecs[v].exp_valid);
         checkOutput("vec_data", r_data, d);
         checkOutput("vec_cnt_at_strobe", r_cnt_strobe, 1);
         checkOutput("vec_done_dly", r_done_dly, vecs[v].exp_done);
         checkOutput("vec_done_cnt", r_done_cnt, (vecs[v].exp_done >= 0) ? 1 : 0);
         checkOutput("vec_err_dly", r_err_dly, vecs[v].exp_err_dly);
         checkOutput("vec_cnt_end", r_cnt_end, vecs[v].exp_cnt_end);
      end

      // Lone frame marker: empty frame still passes through DRAIN and pulses done.
      do_reset();
      tri_last_in = 1'b1;
      tick();
      tri_last_in = 1'b0;
      checkOutput("lone_done", frame_done_out, 1'b1);
      checkOutput("lone_count", tri_count_out, '0);
      checkOutput("lone_valid", rast_valid_out, '0);
      checkOutput("lone_ready_drain", tri_ready_out, 1'b0);
      tick();
      checkOutput("lone_done_off", frame_done_out, 1'b0);
      checkOutput("lone_ready_back", tri_ready_out, 1'b1);

      // Four triangles back-to-back into two slow instances.
      do_reset();
      for (int i = 0; i < N; i++) lat[i] = 20;
      for (int i = 0; i < 4; i++) cdata[i] = rand_tri();
      sent = 0; pend = 0; nstr = 0; dones = 0; viol = 0;
      for (int k = 0; k < 150; k++) begin
         if (rast_valid_out != '0) begin
            if (nstr < 4) begin
               seq[nstr]  = rast_valid_out;
               dseq[nstr] = rast_data_out;
            end
            nstr++;
            pend--;
         end
         if (tri_ready_out && pend > 0) viol++;
         if (frame_done_out) dones++;
         if (sent < 4) begin
            tri_valid_in = 1'b1;
            tri_data_in  = cdata[sent];
            tri_last_in  = (sent == 3);
            if (tri_ready_out) begin
               sent++;
               pend++;
            end
         end else begin
            tri_valid_in = 1'b0;
            tri_last_in  = 1'b0;
         end
         tick();
      end
      checkOutput("b2b_strobes", nstr, 4);
      checkOutput("b2b_ready_while_full", viol, 0);
      checkOutput("b2b_done_pulses", dones, 1);
      for (int i = 0; i < 4; i++) begin
         checkOutput("b2b_order", seq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
         checkOutput("b2b_data", dseq[i], cdata[i]);
      end

      // Reset while draining with both instances busy.
      do_reset();
      for (int i = 0; i < N; i++) lat[i] = 40;
      sent = 0;
      for (int k = 0; k < 30 && busy_out != 2'b11; k++) begin
         if (sent < 2) begin
            tri_valid_in = 1'b1;
            tri_data_in  = rand_tri();
            tri_last_in  = (sent == 1);
            if (tri_ready_out) sent++;
         end else begin
            tri_valid_in = 1'b0;
            tri_last_in  = 1'b0;
         end
         tick();
      end
      tri_valid_in = 1'b0;
      tri_last_in  = 1'b0;
      checkOutput("midrst_precond_busy", busy_out, 2'b11);
      rst_in = 1'b1;
      model_clear();
      tick();
      rst_in = 1'b0;
      checkOutput("midrst_ready", tri_ready_out, 1'b1);
      checkOutput("midrst_valid", rast_valid_out, '0);
      checkOutput("midrst_busy", busy_out, '0);
      checkOutput("midrst_count", tri_count_out, '0);
      checkOutput("midrst_done", frame_done_out, 1'b0);
      checkOutput("midrst_err", timeout_err_out, 1'b0);
      dones = 0;
      for (int k = 0; k < 60; k++) begin
         if (frame_done_out) dones++;
         tick();
      end
      checkOutput("midrst_no_pulse", dones, 0);

      // Randomized traffic against a transaction-level model.
      begin
         logic [TW-1:0] q [$];
         logic [N-1:0]  eb, ev;
         int  m_pending, m_count, m_rr, exp_sel, act_sel, idx, frames;
         bit  m_drain, exp_ready, exp_done, allf, v_in, l_in;
         do_reset();
         rand_lat  = 1'b1;
         m_pending = 0; m_count = 0; m_rr = 0; m_drain = 1'b0; frames = 0;
         for (int c = 0; c < 3000; c++) begin
            if (rast_valid_out != '0) begin
               checkOutput("rnd_onehot", $onehot(rast_valid_out), 1'b1);
               exp_sel = -1;
               for (int k = 0; k < N; k++) begin
                  idx = (m_rr + k) % N;
                  if (exp_sel < 0 && prev_free[idx] <= cyc - 1) exp_sel = idx;
               end
               ev = (exp_sel < 0) ? '0 : N'(1) << exp_sel;
               checkOutput("rnd_sel", rast_valid_out, ev);
               act_sel = 0;
               for (int k = 0; k < N; k++) if (rast_valid_out[k]) act_sel = k;
               m_rr = (act_sel + 1) % N;
               if (q.size() == 0) begin
                  checkOutput("rnd_spurious_issue", 1'b1, 1'b0);
               end else begin
                  checkOutput("rnd_data", rast_data_out, q.pop_front());
                  m_pending--;
               end
               m_count++;
            end
            allf = 1'b1;
            for (int i = 0; i < N; i++) begin
               eb[i] = (free_from[i] > cyc);
               if (eb[i]) allf = 1'b0;
            end
            exp_ready = !m_drain && (m_pending == 0);
            exp_done  = m_drain && (m_pending == 0) && allf;
            checkOutput("rnd_ready", tri_ready_out, exp_ready);
            checkOutput("rnd_done", frame_done_out, exp_done);
            checkOutput("rnd_count", tri_count_out, m_count);
            checkOutput("rnd_busy", busy_out, eb);
            checkOutput("rnd_err", timeout_err_out, 1'b0);
            v_in = (c < 2800) ? ($urandom_range(0, 1) == 1) : 1'b0;
            l_in = v_in && ($urandom_range(0, 5) == 0);
            tri_valid_in = v_in;
            tri_last_in  = l_in;
            tri_data_in  = rand_tri();
            if (v_in && exp_ready) begin
               q.push_back(tri_data_in);
               m_pending++;
            end
            if (exp_ready && l_in) m_drain = 1'b1;
            if (exp_done) begin
               m_drain = 1'b0;
               m_count = 0;
               frames++;
            end
            tick();
         end
         checkOutput("rnd_all_issued", q.size(), 0);
         $display("[TB] random run closed %0d frames", frames);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
